// File: rtl/axis_heartbeat_arbiter.sv
// Packet-granular arbiter for the heartbeat/SFP AXI-Stream mux: one-hot grant held from packet start to tlast.
// Optional watchdog release on a stalled output is enabled with `define AXIS_HB_ARB_WATCHDOG_EN.
`timescale 1ns/1ps

module axis_heartbeat_arbiter #(
  parameter int SFP_PRIORITY   = 1,
  parameter int GAP_CYCLES     = 0,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_heartbeat1,
  input  logic       req_heartbeat2,
  input  logic       req_heartbeat3,
  input  logic       req_SFP,
  input  logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  input  logic       m_axis_tlast,
  output logic       grant_heartbeat1,
  output logic       grant_heartbeat2,
  output logic       grant_heartbeat3,
  output logic       grant_SFP,
  output logic [1:0] grant_id,
  output logic       busy,
  output logic       timeout
);

  // Handshake semantics: a beat moves on the muxed output when m_axis_tvalid and
  // m_axis_tready are both high in the same cycle; the beat carrying m_axis_tlast ends the packet.

  if (GAP_CYCLES < 0 || GAP_CYCLES > 15) begin : g_gap_range
    $error("axis_heartbeat_arbiter: GAP_CYCLES must be within 0..15");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_range
    $error("axis_heartbeat_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOCK = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // With priority SFP the round-robin ring only covers hb1..hb3.
  localparam int RR_N = (SFP_PRIORITY != 0) ? 3 : 4;

  state_t     state;
  logic [1:0] rr_ptr;
  logic [3:0] gap_cnt;
  logic [3:0] grant;
  logic [1:0] grant_id_q;

  logic [3:0] req_vec;
  logic       win_found;
  logic [1:0] win_id;
  logic [1:0] ptr_next;
  logic [2:0] cand;
  logic [2:0] nxt;

  logic       beat_hs;
  logic       pkt_end;
  logic       release_lock;

  assign req_vec = {req_SFP, req_heartbeat3, req_heartbeat2, req_heartbeat1};
  assign beat_hs = m_axis_tvalid & m_axis_tready;
  assign pkt_end = beat_hs & m_axis_tlast;

  always_comb begin
    win_found = 1'b0;
    win_id    = 2'd0;
    ptr_next  = rr_ptr;
    cand      = 3'd0;
    nxt       = 3'd0;
    if ((SFP_PRIORITY != 0) && req_SFP) begin
      win_found = 1'b1;
      win_id    = 2'd3;
    end else begin
      for (int i = 0; i < RR_N; i++) begin
        cand = {1'b0, rr_ptr} + 3'(i);
        if (cand >= 3'(RR_N)) cand = cand - 3'(RR_N);
        if (!win_found && req_vec[cand[1:0]]) begin
          win_found = 1'b1;
          win_id    = cand[1:0];
          nxt       = cand + 3'd1;
          if (nxt >= 3'(RR_N)) nxt = 3'd0;
          ptr_next  = nxt[1:0];
        end
      end
    end
  end

`ifdef AXIS_HB_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_expire;
  logic            timeout_q;

  // The cycle that would bring the count to TIMEOUT_CYCLES releases the grant instead.
  assign wd_expire    = (state == ST_LOCK) && !beat_hs &&
                        (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
  assign release_lock = pkt_end | wd_expire;
  assign timeout      = timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (state == ST_LOCK) begin
      if (beat_hs || wd_expire) begin
        wd_cnt <= '0;
      end else begin
        wd_cnt <= wd_cnt + 1'b1;
      end
      if (wd_expire) begin
        timeout_q <= 1'b1;
      end
    end else begin
      wd_cnt <= '0;
    end
  end
`else
  assign release_lock = pkt_end;
  assign timeout      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      rr_ptr     <= 2'd0;
      gap_cnt    <= 4'd0;
      grant      <= 4'd0;
      grant_id_q <= 2'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (win_found) begin
            grant      <= 4'd1 << win_id;
            grant_id_q <= win_id;
            rr_ptr     <= ptr_next;
            state      <= ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (release_lock) begin
            grant <= 4'd0;
            if (GAP_CYCLES > 0) begin
              gap_cnt <= 4'(GAP_CYCLES - 1);
              state   <= ST_GAP;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= ST_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 4'd0;
        end
      endcase
    end
  end

  assign grant_heartbeat1 = grant[0];
  assign grant_heartbeat2 = grant[1];
  assign grant_heartbeat3 = grant[2];
  assign grant_SFP        = grant[3];
  assign grant_id         = grant_id_q;
  assign busy             = |grant;

endmodule

// File: tb/tb_axis_heartbeat_arbiter.sv
// Directed bench for axis_heartbeat_arbiter: a default instance plus a 4-way round-robin instance with GAP_CYCLES=3.
`timescale 1ns/1ps

module tb_axis_heartbeat_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic req1, req2, req3, req_sfp;
  logic tv, tr, tl;

  logic       a_g1, a_g2, a_g3, a_gs, a_busy, a_timeout;
  logic [1:0] a_id;
  logic       b_g1, b_g2, b_g3, b_gs, b_busy, b_timeout;
  logic [1:0] b_id;

  axis_heartbeat_arbiter dut_a (
    .clk(clk), .rst_n(rst_n),
    .req_heartbeat1(req1), .req_heartbeat2(req2), .req_heartbeat3(req3), .req_SFP(req_sfp),
    .m_axis_tvalid(tv), .m_axis_tready(tr), .m_axis_tlast(tl),
    .grant_heartbeat1(a_g1), .grant_heartbeat2(a_g2), .grant_heartbeat3(a_g3), .grant_SFP(a_gs),
    .grant_id(a_id), .busy(a_busy), .timeout(a_timeout)
  );

  axis_heartbeat_arbiter #(.SFP_PRIORITY(0), .GAP_CYCLES(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .req_heartbeat1(req1), .req_heartbeat2(req2), .req_heartbeat3(req3), .req_SFP(req_sfp),
    .m_axis_tvalid(tv), .m_axis_tready(tr), .m_axis_tlast(tl),
    .grant_heartbeat1(b_g1), .grant_heartbeat2(b_g2), .grant_heartbeat3(b_g3), .grant_SFP(b_gs),
    .grant_id(b_id), .busy(b_busy), .timeout(b_timeout)
  );

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_q[$];
  logic sel;
  logic prev_busy;

  logic [3:0] a_vec, b_vec, obs_grant;
  logic [1:0] obs_id;
  logic       obs_busy, obs_timeout;

  assign a_vec = {a_gs, a_g3, a_g2, a_g1};
  assign b_vec = {b_gs, b_g3, b_g2, b_g1};

  always_comb begin
    obs_grant   = sel ? b_vec : a_vec;
    obs_id      = sel ? b_id : a_id;
    obs_busy    = sel ? b_busy : a_busy;
    obs_timeout = sel ? b_timeout : a_timeout;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic s);
    rst_n = 1'b0;
    req1 = 1'b0; req2 = 1'b0; req3 = 1'b0; req_sfp = 1'b0;
    tv = 1'b0; tr = 1'b0; tl = 1'b0;
    sel = s;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic wait_busy(output int n, input int lim);
    n = 0;
    while (obs_busy !== 1'b1 && n < lim) begin
      tick();
      n++;
    end
    if (obs_busy !== 1'b1) check("wait_grant_bound", 32'(obs_busy), 32'd1);
  endtask

  // Drive one packet on the muxed output; drop lowers the given requests {sfp,hb3,hb2,hb1} with tlast.
  task automatic send_packet(input int beats, input logic [3:0] drop);
    logic [3:0] held;
    held = obs_grant;
    for (int b = 1; b <= beats; b++) begin
      check("grant_hold", 32'(obs_grant), 32'(held));
      tv = 1'b1;
      tr = 1'b1;
      tl = (b == beats);
      if (b == beats) begin
        if (drop[0]) req1 = 1'b0;
        if (drop[1]) req2 = 1'b0;
        if (drop[2]) req3 = 1'b0;
        if (drop[3]) req_sfp = 1'b0;
      end
      tick();
    end
    tv = 1'b0;
    tr = 1'b0;
    tl = 1'b0;
    check("release_after_tlast", 32'(obs_busy), 32'd0);
  endtask

  // Scoreboard pop on every new grant of the observed instance, plus per-cycle invariants on both.
  always @(negedge clk) begin
    logic [1:0] e;
    if (rst_n && obs_busy && !prev_busy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_grant", 32'(obs_id), 32'hdead);
      end else begin
        e = exp_q.pop_front();
        check("sb_grant_id", 32'(obs_id), 32'(e));
        check("sb_grant_vec", 32'(obs_grant), 32'(4'd1 << e));
      end
    end
    prev_busy = obs_busy;
    check("onehot_a", 32'($onehot0(a_vec)), 32'd1);
    check("busy_or_a", 32'(a_busy), 32'(|a_vec));
    check("onehot_b", 32'($onehot0(b_vec)), 32'd1);
    check("busy_or_b", 32'(b_busy), 32'(|b_vec));
  end

  initial begin
    #400000;
    $display("FAIL global_time_limit: simulation did not complete");
    $fatal(1, "time limit");
  end

  initial begin
    int n;
    prev_busy = 1'b0;
    sel = 1'b0;
    rst_n = 1'b0;
    req1 = 1'b0; req2 = 1'b0; req3 = 1'b0; req_sfp = 1'b0;
    tv = 1'b0; tr = 1'b0; tl = 1'b0;

    // Reset values
    #2;
    check("rst_grants", 32'(a_vec), 32'd0);
    check("rst_grant_id", 32'(a_id), 32'd0);
    check("rst_busy", 32'(a_busy), 32'd0);
    check("rst_timeout", 32'(a_timeout), 32'd0);
    check("rst_grants_b", 32'(b_vec), 32'd0);
    tick();

    // Single requester, 4-beat packet
    rst_n = 1'b1;
    req2 = 1'b1;
    exp_q.push_back(2'd1);
    tick();
    check("t1_grant_hb2", 32'(a_g2), 32'd1);
    check("t1_grant_id", 32'(a_id), 32'd1);
    check("t1_busy", 32'(a_busy), 32'd1);
    send_packet(4, 4'b0010);
    check("t1_id_held_after_release", 32'(a_id), 32'd1);
    tick();
    check("t1_idle_no_req", 32'(a_busy), 32'd0);

    // hb1..hb3 round-robin, 2-beat packets, one free cycle between packets
    do_reset(1'b0);
    req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd0);
    wait_busy(n, 4);
    check("t2_latency", 32'(n), 32'd1);
    for (int k = 0; k < 4; k++) begin
      send_packet(2, (k == 3) ? 4'b0111 : 4'b0000);
      if (k < 3) begin
        wait_busy(n, 8);
        check("t2_free_cycles", 32'(n), 32'd1);
      end
    end
    tick();
    check("t2_idle_end", 32'(a_busy), 32'd0);

    // SFP request during an hb2 packet: hb2 keeps it, SFP next, then pointer still at hb3
    do_reset(1'b0);
    req2 = 1'b1;
    exp_q.push_back(2'd1);
    wait_busy(n, 4);
    req_sfp = 1'b1; req1 = 1'b1; req3 = 1'b1;
    exp_q.push_back(2'd3);
    send_packet(3, 4'b0010);
    wait_busy(n, 4);
    check("t3_sfp_free_cycles", 32'(n), 32'd1);
    exp_q.push_back(2'd2);
    send_packet(2, 4'b1000);
    wait_busy(n, 4);
    exp_q.push_back(2'd0);
    send_packet(2, 4'b0100);
    wait_busy(n, 4);
    send_packet(1, 4'b0001);
    tick();

    // 4-way round-robin with GAP_CYCLES=3, single-beat packets
    do_reset(1'b1);
    req1 = 1'b1; req2 = 1'b1; req3 = 1'b1; req_sfp = 1'b1;
    exp_q.push_back(2'd0);
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd2);
    exp_q.push_back(2'd3);
    exp_q.push_back(2'd0);
    wait_busy(n, 4);
    check("t4_latency", 32'(n), 32'd1);
    for (int k = 0; k < 5; k++) begin
      send_packet(1, (k == 4) ? 4'b1111 : 4'b0000);
      if (k < 4) begin
        wait_busy(n, 12);
        check("t4_gap_free_cycles", 32'(n), 32'd4);
      end
    end
    tick();

    // Stalled output: tready low, no tlast
    do_reset(1'b0);
    req1 = 1'b1;
    exp_q.push_back(2'd0);
    wait_busy(n, 4);
    req1 = 1'b0;
    tv = 1'b1;
    tr = 1'b0;
    tl = 1'b0;
`ifdef AXIS_HB_ARB_WATCHDOG_EN
    repeat (1023) tick();
    check("wd_held_1024", 32'(a_busy), 32'd1);
    check("wd_no_timeout_yet", 32'(a_timeout), 32'd0);
    tick();
    check("wd_release_1025", 32'(a_busy), 32'd0);
    check("wd_timeout_set", 32'(a_timeout), 32'd1);
    tv = 1'b0;
    repeat (5) tick();
    check("wd_timeout_sticky", 32'(a_timeout), 32'd1);
`else
    repeat (1999) tick();
    check("nowd_held_2000", 32'(a_g1), 32'd1);
    check("nowd_timeout_zero", 32'(a_timeout), 32'd0);
    tr = 1'b1;
    tl = 1'b1;
    tick();
    tv = 1'b0; tr = 1'b0; tl = 1'b0;
    check("nowd_release_on_tlast", 32'(a_busy), 32'd0);
`endif

    // Reset during beat 2 of an SFP packet
    do_reset(1'b0);
    check("t6_timeout_cleared", 32'(obs_timeout), 32'd0);
    req2 = 1'b1;
    exp_q.push_back(2'd1);
    wait_busy(n, 4);
    send_packet(1, 4'b0010);
    req_sfp = 1'b1;
    exp_q.push_back(2'd3);
    wait_busy(n, 4);
    check("t6_sfp_latency", 32'(n), 32'd1);
    tv = 1'b1; tr = 1'b1; tl = 1'b0;
    tick();
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_async_drop_sfp", 32'(a_gs), 32'd0);
    check("t6_async_busy", 32'(a_busy), 32'd0);
    req_sfp = 1'b0;
    tv = 1'b0; tr = 1'b0;
    req1 = 1'b1; req2 = 1'b1; req3 = 1'b1;
    tick();
    rst_n = 1'b1;
    exp_q.push_back(2'd0);
    wait_busy(n, 4);
    check("t6_fresh_latency", 32'(n), 32'd1);
    check("t6_fresh_hb1", 32'(a_g1), 32'd1);
    send_packet(1, 4'b0111);
    tick();

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_heartbeat_arbiter.md
Name: axis_heartbeat_arbiter

Overview:
- Packet-granular arbiter that drives the four grant lines of the heartbeat/SFP AXI-Stream multiplexer: grant_heartbeat1, grant_heartbeat2, grant_heartbeat3 and grant_SFP.
- Watches source tvalid as requests and the muxed output handshake for packet end.
- Holds a one-hot grant from packet start through the tlast beat, then re-arbitrates.
- Sits beside the multiplexer in the Heartbeat app, between the three heartbeat generators plus the SFP path and the TX interface.

Parameters:
- SFP_PRIORITY, 1, 1 = SFP wins whenever requesting; 0 = SFP joins the round-robin as an equal.
- GAP_CYCLES, 0, extra idle cycles inserted after each packet before re-arbitration (0..15).
- TIMEOUT_CYCLES, 1024, watchdog limit in cycles with no output handshake while granted (used only with the optional feature).

Ports:
- clk  in  1  block clock
- rst_n  in  1  asynchronous active-low reset
- req_heartbeat1  in  1  s_axis_heartbeat1_tvalid
- req_heartbeat2  in  1  s_axis_heartbeat2_tvalid
- req_heartbeat3  in  1  s_axis_heartbeat3_tvalid
- req_SFP  in  1  s_axis_SFP_tvalid
- m_axis_tvalid  in  1  muxed output tvalid
- m_axis_tready  in  1  muxed output tready
- m_axis_tlast  in  1  muxed output tlast
- grant_heartbeat1  out  1  registered grant
- grant_heartbeat2  out  1  registered grant
- grant_heartbeat3  out  1  registered grant
- grant_SFP  out  1  registered grant
- grant_id  out  2  encoded owner: 0=hb1, 1=hb2, 2=hb3, 3=SFP; valid while busy
- busy  out  1  a grant is held
- timeout  out  1  sticky watchdog flag

Behaviour:
- Reset (rst_n low, asynchronous):
  - all grants 0, grant_id 0, busy 0, timeout 0
  - state IDLE, round-robin pointer 0 (hb1 highest), gap counter 0
  - Deassertion takes effect on the next clk edge.
- IDLE state:
  - If any req is high, the winner is chosen combinationally and its grant registered at the next edge (1-cycle request-to-grant latency). Move to LOCK.
  - If no req is high, stay in IDLE with all grants 0.
- Arbitration:
  - SFP_PRIORITY=1: SFP wins if req_SFP=1; otherwise round-robin among hb1..hb3.
  - SFP_PRIORITY=0: 4-way round-robin over hb1, hb2, hb3, SFP.
  - The pointer advances to one past the winner when the grant is issued. A priority SFP win does not move the pointer.
- LOCK state:
  - The grant is held unchanged regardless of req changes; a requester dropping tvalid mid-packet does not release the grant.
  - Release event: m_axis_tvalid & m_axis_tready & m_axis_tlast in one cycle. Grants go 0 at the next edge.
  - After release, go to GAP if GAP_CYCLES>0, else IDLE.
  - Minimum one grant-free cycle between packets (IDLE evaluation cycle).
  - A single-beat packet (tlast on the first beat) releases normally.
- GAP state:
  - Counter loads GAP_CYCLES-1 on entry and decrements each cycle. Exit to IDLE when it reaches 0.
  - Grants stay 0 throughout.
- Invariants:
  - Grants are one-hot or all zero, every cycle.
  - busy = OR of grants.
  - grant_id is updated with the grant and holds its value after release.
- Mid-packet reset: grants drop immediately (asynchronously); the partial packet is not tracked or flushed.

Optional Feature:
- Macro: AXIS_HB_ARB_WATCHDOG_EN.
- With the macro:
  - In LOCK, a counter increments each cycle without an output handshake (tvalid&tready) and clears on every handshake.
  - When it reaches TIMEOUT_CYCLES, the grant is forcibly released at the next edge (same path as a normal release) and timeout is set.
  - timeout is sticky until rst_n.
- Without the macro: no counter logic; timeout is tied to 0; LOCK exits only on tlast.

Test Plan:
- Reset, then req_heartbeat2=1 -> grant_heartbeat2=1 on cycle 1, grant_id=1, busy=1; hold a 4-beat packet with tready=1 -> grant drops the cycle after the tlast beat.
- hb1, hb2, hb3 all requesting continuously, 2-beat packets, SFP_PRIORITY=1 -> grant order hb1, hb2, hb3, hb1, with exactly one grant-free cycle between packets.
- hb2 in LOCK, req_SFP rises mid-packet -> hb2 keeps the grant until tlast; SFP is granted next; the pointer still selects hb3 after SFP.
- SFP_PRIORITY=0, all four requesting -> order hb1, hb2, hb3, SFP, hb1. GAP_CYCLES=3 -> 4 grant-free cycles between packets.
- Grant held with tready=0 and no tlast for 1024 cycles:
  - with AXIS_HB_ARB_WATCHDOG_EN: grant drops on cycle 1025 and timeout=1 stays set;
  - without the macro: grant is still held at cycle 2000 and timeout=0.
- rst_n pulled low during beat 2 of an SFP packet -> grant_SFP=0 immediately; after release, the first grant follows fresh pointer order (hb1 first).
